// File: rtl/nes_mem_pkg.sv
// rtl/nes_mem_pkg.sv - shared types and region bases for the NES CPU-side memory map
package nes_mem_pkg;

    // Region of a decoded CPU address; NONE is the unmapped $4000-$5FFF hole.
    typedef enum logic [2:0] {
        NONE = 3'd0,
        RAM  = 3'd1,
        IO   = 3'd2,
        SRAM = 3'd3,
        ROM  = 3'd4
    } region_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } fsm_state_t;

    localparam logic [15:0] RAM_BASE  = 16'h0000;
    localparam logic [15:0] IO_BASE   = 16'h2000;
    localparam logic [15:0] SRAM_BASE = 16'h6000;
    localparam logic [15:0] ROM_BASE  = 16'h8000;

endpackage

// File: rtl/nes_cpu_mem_map_if.sv
// rtl/nes_cpu_mem_map_if.sv - CPU memory bus between the 6502 core and the memory map
// master: CPU side (drives ren/wen/address/write data, sees read data and rdy)
// slave:  memory side (the reverse)
interface nes_cpu_mem_map_if;
    logic        ren;
    logic        wen;
    logic [15:0] cpu_addr_out;
    logic [7:0]  cpu_data_out;
    logic [7:0]  cpu_data_in;
    logic        rdy;

    modport master (
        output ren, wen, cpu_addr_out, cpu_data_out,
        input  cpu_data_in, rdy
    );

    modport slave (
        input  ren, wen, cpu_addr_out, cpu_data_out,
        output cpu_data_in, rdy
    );
endinterface

// File: rtl/nes_addr_decode.sv
// rtl/nes_addr_decode.sv - combinational address to region/index/wait-count decoder
// addr     : 16-bit bus address
// region   : decoded region
// *_idx    : array index per region (truncation gives the mirroring)
// wait_cnt : wait states of the decoded region (0 for NONE)
module nes_addr_decode
    import nes_mem_pkg::*;
#(
    parameter int RAM_AW    = 11,
    parameter int IO_AW     = 3,
    parameter int SRAM_AW   = 13,
    parameter int ROM_AW    = 15,
    parameter int RAM_WAIT  = 0,
    parameter int IO_WAIT   = 0,
    parameter int SRAM_WAIT = 1,
    parameter int ROM_WAIT  = 2,
    parameter int WAIT_W    = 4
) (
    input  logic [15:0]        addr,
    output region_t            region,
    output logic [RAM_AW-1:0]  ram_idx,
    output logic [IO_AW-1:0]   io_idx,
    output logic [SRAM_AW-1:0] sram_idx,
    output logic [ROM_AW-1:0]  rom_idx,
    output logic [WAIT_W-1:0]  wait_cnt
);

    assign ram_idx  = addr[RAM_AW-1:0];
    assign io_idx   = addr[IO_AW-1:0];
    assign sram_idx = addr[SRAM_AW-1:0];
    assign rom_idx  = addr[ROM_AW-1:0];

    always_comb begin
        region   = NONE;
        wait_cnt = '0;
        if (addr[15]) begin
            region   = ROM;
            wait_cnt = WAIT_W'(ROM_WAIT);
        end else begin
            case (addr[15:13])
                RAM_BASE[15:13]: begin
                    region   = RAM;
                    wait_cnt = WAIT_W'(RAM_WAIT);
                end
                IO_BASE[15:13]: begin
                    region   = IO;
                    wait_cnt = WAIT_W'(IO_WAIT);
                end
                SRAM_BASE[15:13]: begin
                    region   = SRAM;
                    wait_cnt = WAIT_W'(SRAM_WAIT);
                end
                default: begin
                    region   = NONE;
                    wait_cnt = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/nes_cpu_mem_map.sv
// rtl/nes_cpu_mem_map.sv - decoded NES CPU memory map with per-region wait states
// clk, b_rst : clock, asynchronous active-high reset
// bus        : CPU memory bus (slave side)
// ld_*       : ROM preload write port, honoured only while idle with no CPU request
// err_*      : sticky error flags, cleared only by reset
// region_o   : region of the last accepted access
module nes_cpu_mem_map
    import nes_mem_pkg::*;
#(
    parameter int RAM_AW    = 11,
    parameter int IO_AW     = 3,
    parameter int SRAM_AW   = 13,
    parameter int ROM_AW    = 15,
    parameter int RAM_WAIT  = 0,
    parameter int IO_WAIT   = 0,
    parameter int SRAM_WAIT = 1,
    parameter int ROM_WAIT  = 2,
    parameter int WAIT_W    = 4
) (
    input  logic               clk,
    input  logic               b_rst,
    nes_cpu_mem_map_if.slave   bus,
    input  logic               ld_en,
    input  logic [ROM_AW-1:0]  ld_addr,
    input  logic [7:0]         ld_data,
    output logic               err_rom_wr,
    output logic               err_rw_both,
    output region_t            region_o
);

    fsm_state_t state, state_nxt;

    logic [15:0]       addr_q;
    logic [7:0]        wdata_q;
    logic              write_q;
    logic [WAIT_W-1:0] cnt;
    logic [7:0]        data_q;     // doubles as the open-bus latch
    logic [7:0]        io_regs [2**IO_AW];
    logic [7:0]        ram     [2**RAM_AW];
    logic [7:0]        sram    [2**SRAM_AW];
    logic [7:0]        rom     [2**ROM_AW];

    logic              req;
    logic              accept;
    logic              act;        // memory action happens on this edge (entry to RESP)
    logic [15:0]       eff_addr;
    logic [7:0]        eff_wdata;
    logic              eff_write;
    logic [7:0]        rd_data;

    region_t            region;
    logic [RAM_AW-1:0]  ram_idx;
    logic [IO_AW-1:0]   io_idx;
    logic [SRAM_AW-1:0] sram_idx;
    logic [ROM_AW-1:0]  rom_idx;
    logic [WAIT_W-1:0]  wait_cnt;

    assign req    = bus.ren | bus.wen;
    assign accept = (state == IDLE) && req;

    // A zero-wait access acts on the accepting edge straight from the bus;
    // a waited one acts later from the captured copy.
    assign eff_addr  = (state == IDLE) ? bus.cpu_addr_out : addr_q;
    assign eff_wdata = (state == IDLE) ? bus.cpu_data_out : wdata_q;
    assign eff_write = (state == IDLE) ? bus.wen          : write_q;

    nes_addr_decode #(
        .RAM_AW   (RAM_AW),
        .IO_AW    (IO_AW),
        .SRAM_AW  (SRAM_AW),
        .ROM_AW   (ROM_AW),
        .RAM_WAIT (RAM_WAIT),
        .IO_WAIT  (IO_WAIT),
        .SRAM_WAIT(SRAM_WAIT),
        .ROM_WAIT (ROM_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_decode (
        .addr    (eff_addr),
        .region  (region),
        .ram_idx (ram_idx),
        .io_idx  (io_idx),
        .sram_idx(sram_idx),
        .rom_idx (rom_idx),
        .wait_cnt(wait_cnt)
    );

    always_comb begin
        state_nxt = state;
        act       = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (wait_cnt == '0) begin
                        state_nxt = RESP;
                        act       = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt <= WAIT_W'(1)) begin
                    state_nxt = RESP;
                    act       = 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        case (region)
            RAM:     rd_data = ram[ram_idx];
            IO:      rd_data = io_regs[io_idx];
            SRAM:    rd_data = sram[sram_idx];
            ROM:     rd_data = rom[rom_idx];
            default: rd_data = data_q;
        endcase
    end

    assign bus.rdy         = (state != WAIT);
    assign bus.cpu_data_in = data_q;

    always_ff @(posedge clk or posedge b_rst) begin
        if (b_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            data_q      <= '0;
            err_rom_wr  <= 1'b0;
            err_rw_both <= 1'b0;
            region_o    <= NONE;
            for (int i = 0; i < 2**IO_AW; i++) begin
                io_regs[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q   <= bus.cpu_addr_out;
                wdata_q  <= bus.cpu_data_out;
                write_q  <= bus.wen;
                region_o <= region;
                cnt      <= wait_cnt;
                if (bus.ren && bus.wen) begin
                    err_rw_both <= 1'b1;
                end
            end else if (state == WAIT) begin
                cnt <= cnt - WAIT_W'(1);
            end
            if (act) begin
                if (eff_write) begin
                    if (region == IO) begin
                        io_regs[io_idx] <= eff_wdata;
                    end
                    if (region == ROM) begin
                        err_rom_wr <= 1'b1;
                    end
                end else begin
                    data_q <= rd_data;
                end
            end
        end
    end

    // Array contents survive reset; the reset branch only blocks writes while
    // reset is held so an aborted access can never land.
    always_ff @(posedge clk or posedge b_rst) begin
        if (!b_rst) begin
            if (act && eff_write) begin
                case (region)
                    RAM:     ram[ram_idx]   <= eff_wdata;
                    SRAM:    sram[sram_idx] <= eff_wdata;
                    default: ;
                endcase
            end
            if (ld_en && (state == IDLE) && !req) begin
                rom[ld_addr] <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_nes_cpu_mem_map.sv
// tb/tb_nes_cpu_mem_map.sv - scoreboard bench for nes_cpu_mem_map
module tb_nes_cpu_mem_map;
    import nes_mem_pkg::*;

    logic        clk = 1'b0;
    logic        b_rst;
    logic        ld_en;
    logic [14:0] ld_addr;
    logic [7:0]  ld_data;
    logic        err_rom_wr;
    logic        err_rw_both;
    region_t     region_o;

    always #5 clk = ~clk;

    nes_cpu_mem_map_if bus ();

    nes_cpu_mem_map u_dut (
        .clk        (clk),
        .b_rst      (b_rst),
        .bus        (bus),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .err_rom_wr (err_rom_wr),
        .err_rw_both(err_rw_both),
        .region_o   (region_o)
    );

    typedef struct {
        logic        is_read;
        logic [7:0]  data;
        int          waits;
        string       name;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   busy  = 0;
    int   wcnt  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: tracks acceptance itself, counts rdy-low cycles, compares at the response cycle.
    always @(posedge clk) begin
        if (!b_rst && !busy && (bus.ren || bus.wen)) begin
            busy = 1;
            wcnt = 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_rst) begin
            busy = 0;
        end else if (busy) begin
            if (!bus.rdy) begin
                wcnt++;
                if (wcnt > 20) begin
                    check("monitor_wait_bound", 32'(wcnt), 32'd20);
                    busy = 0;
                end
            end else begin
                if (q.size() == 0) begin
                    check("unexpected_response", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check({e.name, "_waits"}, 32'(wcnt), 32'(e.waits));
                    if (e.is_read) begin
                        check({e.name, "_data"}, {24'd0, bus.cpu_data_in}, {24'd0, e.data});
                    end
                end
                busy = 0;
            end
        end
    end

    task automatic access(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d,
                          input logic [7:0] exp, input int waits, input string nm);
        exp_t e;
        bit   done;
        @(negedge clk);
        bus.ren          = r;
        bus.wen          = w;
        bus.cpu_addr_out = a;
        bus.cpu_data_out = d;
        e.is_read = r & ~w;
        e.data    = exp;
        e.waits   = waits;
        e.name    = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
        bus.ren = 1'b0;
        bus.wen = 1'b0;
        done = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (bus.rdy) done = 1;
        end
        if (!done) check({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic preload(input logic [14:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        b_rst            = 1'b1;
        bus.ren          = 1'b0;
        bus.wen          = 1'b0;
        bus.cpu_addr_out = 16'h0000;
        bus.cpu_data_out = 8'h00;
        ld_en            = 1'b0;
        ld_addr          = '0;
        ld_data          = '0;
        repeat (3) @(negedge clk);
        b_rst = 1'b0;
        #1;
        check("rst_rdy", {31'd0, bus.rdy}, 32'd1);
        check("rst_data", {24'd0, bus.cpu_data_in}, 32'd0);
        check("rst_err_rom_wr", {31'd0, err_rom_wr}, 32'd0);
        check("rst_err_rw_both", {31'd0, err_rw_both}, 32'd0);
        check("rst_region", 32'(region_o), 32'(NONE));

        // RAM write, mirrored read, no stalls
        access(1'b0, 1'b1, 16'h0005, 8'hA5, 8'h00, 0, "ram_wr_0005");
        access(1'b1, 1'b0, 16'h0805, 8'h00, 8'hA5, 0, "ram_rd_0805");
        check("region_ram", 32'(region_o), 32'(RAM));

        // ROM preload and reset vector reads, 2 wait states each
        preload(15'h7FFC, 8'h00);
        preload(15'h7FFD, 8'h80);
        preload(15'h0000, 8'h11);
        preload(15'h0001, 8'h22);
        access(1'b1, 1'b0, 16'hFFFC, 8'h00, 8'h00, 2, "rom_rd_fffc");
        access(1'b1, 1'b0, 16'hFFFD, 8'h00, 8'h80, 2, "rom_rd_fffd");
        check("region_rom", 32'(region_o), 32'(ROM));

        // SRAM, 1 wait state both directions
        access(1'b0, 1'b1, 16'h6000, 8'h3C, 8'h00, 1, "sram_wr_6000");
        access(1'b1, 1'b0, 16'h6000, 8'h00, 8'h3C, 1, "sram_rd_6000");

        // open bus and ROM write protection
        access(1'b0, 1'b1, 16'h0123, 8'h5A, 8'h00, 0, "ram_wr_0123");
        access(1'b1, 1'b0, 16'h0123, 8'h00, 8'h5A, 0, "ram_rd_0123");
        access(1'b1, 1'b0, 16'h4800, 8'h00, 8'h5A, 0, "openbus_rd_4800");
        check("region_none", 32'(region_o), 32'(NONE));
        check("err_rom_wr_before", {31'd0, err_rom_wr}, 32'd0);
        access(1'b0, 1'b1, 16'h8000, 8'hFF, 8'h00, 2, "rom_wr_8000");
        check("err_rom_wr_set", {31'd0, err_rom_wr}, 32'd1);
        access(1'b1, 1'b0, 16'h8000, 8'h00, 8'h11, 2, "rom_rd_8000");

        // ren and wen together behave as a write
        check("err_rw_both_before", {31'd0, err_rw_both}, 32'd0);
        access(1'b1, 1'b1, 16'h0010, 8'h77, 8'h00, 0, "rw_both_0010");
        check("err_rw_both_set", {31'd0, err_rw_both}, 32'd1);
        access(1'b1, 1'b0, 16'h0010, 8'h00, 8'h77, 0, "ram_rd_0010");

        // IO register and its mirror
        access(1'b0, 1'b1, 16'h2003, 8'hC7, 8'h00, 0, "io_wr_2003");
        access(1'b1, 1'b0, 16'h2003, 8'h00, 8'hC7, 0, "io_rd_2003");
        access(1'b1, 1'b0, 16'h200B, 8'h00, 8'hC7, 0, "io_rd_200b");
        check("region_io", 32'(region_o), 32'(IO));

        // preload held through a non-idle edge and a coinciding CPU request is dropped
        ld_en   = 1'b1;
        ld_addr = 15'h0001;
        ld_data = 8'h99;
        access(1'b1, 1'b0, 16'h8001, 8'h00, 8'h22, 2, "rom_rd_8001_ld");
        ld_en = 1'b0;
        access(1'b1, 1'b0, 16'h8001, 8'h00, 8'h22, 2, "rom_rd_8001_again");

        // reset during a ROM wait
        @(negedge clk);
        bus.ren          = 1'b1;
        bus.cpu_addr_out = 16'hFFFC;
        @(posedge clk);
        #1;
        bus.ren = 1'b0;
        @(negedge clk);
        check("abort_in_wait", {31'd0, bus.rdy}, 32'd0);
        #2;
        b_rst = 1'b1;
        #1;
        check("abort_rdy", {31'd0, bus.rdy}, 32'd1);
        check("abort_data", {24'd0, bus.cpu_data_in}, 32'd0);
        check("abort_err_rom_wr", {31'd0, err_rom_wr}, 32'd0);
        check("abort_err_rw_both", {31'd0, err_rw_both}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        b_rst = 1'b0;
        access(1'b1, 1'b0, 16'h2003, 8'h00, 8'h00, 0, "io_rd_after_rst");
        access(1'b1, 1'b0, 16'h0010, 8'h00, 8'h77, 0, "ram_rd_after_rst");
        access(1'b1, 1'b0, 16'h0805, 8'h00, 8'hA5, 0, "ram_rd_0805_after_rst");
        access(1'b1, 1'b0, 16'hFFFD, 8'h00, 8'h80, 2, "rom_rd_after_rst");

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
